// File: rtl/multi_sync_debounce.sv
// Multi-channel CDC synchronizer with per-channel debounce filter and edge pulses.
// Each channel is synchronized, then must hold a new level for T cycles before the output follows.
module multi_sync_debounce #(
   parameter int               WIDTH      = 5,
   parameter int               STAGES     = 2,
   parameter int               FILTER_LEN = 4,
   parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}}
) (
   input  logic             cdc_clk,
   input  logic             cdc_rstn,
   input  logic [WIDTH-1:0] input_signal,
   input  logic             filter_en,
   output logic [WIDTH-1:0] output_signal,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse,
   output logic             change_any
);

   localparam int               CNT_W   = $clog2(FILTER_LEN + 1);
   localparam logic [CNT_W-1:0] FILT_M1 = CNT_W'(FILTER_LEN - 1);

   logic [WIDTH-1:0] sync_q [STAGES];
   logic [WIDTH-1:0] sync_d [STAGES];
   logic [CNT_W-1:0] cnt_q  [WIDTH];
   logic [CNT_W-1:0] cnt_d  [WIDTH];
   logic [WIDTH-1:0] out_q, out_d;
   logic [WIDTH-1:0] rise_q, rise_d;
   logic [WIDTH-1:0] fall_q, fall_d;
   logic [WIDTH-1:0] sync_out;
   logic [CNT_W-1:0] thr_m1;

   always_comb begin
      sync_d[0] = input_signal;
      for (int s = 1; s < STAGES; s++) begin
         sync_d[s] = sync_q[s-1];
      end
   end

   assign sync_out = sync_q[STAGES-1];

   // Compare against T-1 with >= so a threshold drop mid-count fires on the next differing edge.
   always_comb begin
      thr_m1 = filter_en ? FILT_M1 : '0;
      out_d  = out_q;
      rise_d = '0;
      fall_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = '0;
         if (sync_out[i] != out_q[i]) begin
            if (cnt_q[i] >= thr_m1) begin
               out_d[i]  = sync_out[i];
               rise_d[i] = sync_out[i];
               fall_d[i] = ~sync_out[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge cdc_clk) begin
      if (!cdc_rstn) begin
         for (int s = 0; s < STAGES; s++) begin
            sync_q[s] <= RESET_VAL;
         end
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
         out_q  <= RESET_VAL;
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         for (int s = 0; s < STAGES; s++) begin
            sync_q[s] <= sync_d[s];
         end
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         out_q  <= out_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign output_signal = out_q;
   assign rise_pulse    = rise_q;
   assign fall_pulse    = fall_q;
   assign change_any    = |(rise_q | fall_q);

endmodule

// File: tb/tb_multi_sync_debounce.sv
// Bench for multi_sync_debounce: vector table, directed corner sequences, and
// randomized traffic checked against a run-length reference model.
module tb_multi_sync_debounce;
   localparam int W = 5;
   localparam int S = 2;
   localparam int F = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rstn;
   logic         fen;
   logic [W-1:0] inp;
   logic [W-1:0] out, rise, fall;
   logic         any;

   multi_sync_debounce #(
      .WIDTH(W), .STAGES(S), .FILTER_LEN(F), .RESET_VAL({W{1'b0}})
   ) dut (
      .cdc_clk(clk), .cdc_rstn(rstn), .input_signal(inp), .filter_en(fen),
      .output_signal(out), .rise_pulse(rise), .fall_pulse(fall), .change_any(any)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: input delayed S edges, then a level must be seen differing for T edges in a row.
   logic [W-1:0] m_pipe [S];
   logic [W-1:0] m_out, m_rise, m_fall;
   int           m_run [W];

   typedef struct {
      logic         rstn;
      logic         fen;
      logic [W-1:0] inp;
      logic [W-1:0] out;
      logic [W-1:0] rise;
      logic [W-1:0] fall;
      logic         any;
   } vec_t;
   vec_t tbl [14];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      logic [W-1:0] s;
      int           t;
      if (!rstn) begin
         for (int k = 0; k < S; k++) m_pipe[k] = '0;
         m_out  = '0;
         m_rise = '0;
         m_fall = '0;
         for (int i = 0; i < W; i++) m_run[i] = 0;
      end else begin
         s = m_pipe[S-1];
         for (int k = S-1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
         m_pipe[0] = inp;
         t = fen ? F : 1;
         m_rise = '0;
         m_fall = '0;
         for (int i = 0; i < W; i++) begin
            if (s[i] != m_out[i]) begin
               m_run[i] = m_run[i] + 1;
               if (m_run[i] >= t) begin
                  m_out[i] = s[i];
                  if (s[i]) m_rise[i] = 1'b1;
                  else      m_fall[i] = 1'b1;
                  m_run[i] = 0;
               end
            end else begin
               m_run[i] = 0;
            end
         end
      end
   endtask

   task automatic step(input logic r, input logic f, input logic [W-1:0] d);
      rstn = r;
      fen  = f;
      inp  = d;
      @(posedge clk);
      model_edge();
      #1;
      chk("model_out",  32'(out),  32'(m_out));
      chk("model_rise", 32'(rise), 32'(m_rise));
      chk("model_fall", 32'(fall), 32'(m_fall));
      chk("model_any",  32'(any),  32'(|(m_rise | m_fall)));
      chk("rise_fall_excl", 32'(rise & fall), 32'd0);
   endtask

   int           nrise, nfall;
   logic [W-1:0] rin;
   logic         rfen;

   initial begin
      rstn = 1'b0;
      fen  = 1'b0;
      inp  = '0;
      for (int k = 0; k < S; k++) m_pipe[k] = '0;
      m_out = '0; m_rise = '0; m_fall = '0;
      for (int i = 0; i < W; i++) m_run[i] = 0;

      // reset with all inputs high, then bypass rise, then filtered fall
      tbl[0]  = '{1'b0, 1'b0, 5'h1F, 5'h00, 5'h00, 5'h00, 1'b0};
      tbl[1]  = '{1'b0, 1'b0, 5'h1F, 5'h00, 5'h00, 5'h00, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 5'h1F, 5'h00, 5'h00, 5'h00, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 5'h03, 5'h00, 5'h00, 5'h00, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 5'h03, 5'h00, 5'h00, 5'h00, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 5'h03, 5'h03, 5'h03, 5'h00, 1'b1};
      tbl[6]  = '{1'b1, 1'b0, 5'h03, 5'h03, 5'h00, 5'h00, 1'b0};
      tbl[7]  = '{1'b1, 1'b1, 5'h00, 5'h03, 5'h00, 5'h00, 1'b0};
      tbl[8]  = '{1'b1, 1'b1, 5'h00, 5'h03, 5'h00, 5'h00, 1'b0};
      tbl[9]  = '{1'b1, 1'b1, 5'h00, 5'h03, 5'h00, 5'h00, 1'b0};
      tbl[10] = '{1'b1, 1'b1, 5'h00, 5'h03, 5'h00, 5'h00, 1'b0};
      tbl[11] = '{1'b1, 1'b1, 5'h00, 5'h03, 5'h00, 5'h00, 1'b0};
      tbl[12] = '{1'b1, 1'b1, 5'h00, 5'h00, 5'h00, 5'h03, 1'b1};
      tbl[13] = '{1'b1, 1'b1, 5'h00, 5'h00, 5'h00, 5'h00, 1'b0};

      for (int v = 0; v < 14; v++) begin
         step(tbl[v].rstn, tbl[v].fen, tbl[v].inp);
         chk("tbl_out",  32'(out),  32'(tbl[v].out));
         chk("tbl_rise", 32'(rise), 32'(tbl[v].rise));
         chk("tbl_fall", 32'(fall), 32'(tbl[v].fall));
         chk("tbl_any",  32'(any),  32'(tbl[v].any));
      end

      // filtered rise and fall on channel 0: output moves on the 6th edge
      for (int k = 1; k <= 7; k++) begin
         step(1'b1, 1'b1, 5'h01);
         chk("filt_rise_out0", 32'(out[0]),  32'(k >= 6));
         chk("filt_rise_pls0", 32'(rise[0]), 32'(k == 6));
      end
      for (int k = 1; k <= 7; k++) begin
         step(1'b1, 1'b1, 5'h00);
         chk("filt_fall_out0", 32'(out[0]),  32'(k < 6));
         chk("filt_fall_pls0", 32'(fall[0]), 32'(k == 6));
      end

      // 3-cycle glitch on channel 2 is rejected
      for (int k = 1; k <= 11; k++) begin
         step(1'b1, 1'b1, (k <= 3) ? 5'h04 : 5'h00);
         chk("glitch_out2",  32'(out[2]),  32'd0);
         chk("glitch_rise2", 32'(rise[2]), 32'd0);
      end
      // 4-cycle pulse on channel 2 is accepted, then released
      nrise = 0;
      nfall = 0;
      for (int k = 1; k <= 14; k++) begin
         step(1'b1, 1'b1, (k <= 4) ? 5'h04 : 5'h00);
         nrise += int'(rise[2]);
         nfall += int'(fall[2]);
         if (k == 6) chk("accept_rise2", 32'(rise[2]), 32'd1);
      end
      chk("accept_nrise2", 32'(nrise), 32'd1);
      chk("accept_nfall2", 32'(nfall), 32'd1);

      // filter disabled while channel 4 count is 2
      nrise = 0;
      for (int k = 1; k <= 4; k++) begin
         step(1'b1, 1'b1, 5'h10);
         chk("mode_hold_out4", 32'(out[4]), 32'd0);
      end
      step(1'b1, 1'b0, 5'h10);
      chk("mode_out4",  32'(out[4]),  32'd1);
      chk("mode_rise4", 32'(rise[4]), 32'd1);
      nrise += int'(rise[4]);
      for (int k = 1; k <= 3; k++) begin
         step(1'b1, 1'b0, 5'h10);
         nrise += int'(rise[4]);
      end
      chk("mode_nrise4", 32'(nrise), 32'd1);
      for (int k = 1; k <= 4; k++) step(1'b1, 1'b0, 5'h00);
      chk("mode_back_out", 32'(out), 32'd0);

      // reset while channel 1 is counting down
      for (int k = 1; k <= 4; k++) step(1'b1, 1'b0, 5'h02);
      chk("rstmid_pre_out1", 32'(out[1]), 32'd1);
      nfall = 0;
      step(1'b1, 1'b1, 5'h00);
      nfall += int'(fall[1]);
      step(1'b1, 1'b1, 5'h00);
      nfall += int'(fall[1]);
      step(1'b0, 1'b1, 5'h00);
      chk("rstmid_out1", 32'(out[1]), 32'd0);
      nfall += int'(fall[1]);
      for (int k = 1; k <= 6; k++) begin
         step(1'b1, 1'b1, 5'h00);
         nfall += int'(fall[1]);
         chk("rstmid_after_out", 32'(out), 32'd0);
      end
      chk("rstmid_nfall1", 32'(nfall), 32'd0);

      // first sampling after release with inputs differing from reset value
      step(1'b0, 1'b0, 5'h1F);
      step(1'b1, 1'b0, 5'h1F);
      step(1'b1, 1'b0, 5'h1F);
      chk("release_pre_out", 32'(out), 32'd0);
      step(1'b1, 1'b0, 5'h1F);
      chk("release_out",  32'(out),  32'h1F);
      chk("release_rise", 32'(rise), 32'h1F);

      // randomized traffic against the model
      rin  = 5'h1F;
      rfen = 1'b1;
      for (int n = 0; n < 600; n++) begin
         rin = rin ^ W'($urandom & $urandom & $urandom);
         if ($urandom_range(0, 19) == 0) rfen = ~rfen;
         step(($urandom_range(0, 59) != 0), rfen, rin);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/multi_sync_debounce.md
MULTI_SYNC_DEBOUNCE -- requirements
Module: multi_sync_debounce

Interface
REQ-001 SHALL provide parameter WIDTH, default 5, number of independent channels.
REQ-002 SHALL provide parameter STAGES, default 2, synchronizer chain depth per channel; legal range 2..4.
REQ-003 SHALL provide parameter FILTER_LEN, default 4, debounce threshold in cycles; legal range 1..255.
REQ-004 SHALL provide parameter RESET_VAL, default {WIDTH{1'b0}}, reset value of sync chain and output_signal.
REQ-005 SHALL provide: cdc_clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL provide: cdc_rstn  input  1  reset; synchronous, active-low.
REQ-007 SHALL provide: input_signal  input  WIDTH  asynchronous/foreign-domain level inputs.
REQ-008 SHALL provide: filter_en  input  1  in cdc_clk domain; 1 = debounce with FILTER_LEN, 0 = threshold forced to 1.
REQ-009 SHALL provide: output_signal  output  WIDTH  registered, synchronized, filtered level.
REQ-010 SHALL provide: rise_pulse  output  WIDTH  registered one-cycle pulse per channel on output 0->1.
REQ-011 SHALL provide: fall_pulse  output  WIDTH  registered one-cycle pulse per channel on output 1->0.
REQ-012 SHALL provide: change_any  output  1  OR of all rise_pulse and fall_pulse bits.

Function
REQ-013 Each channel SHALL pass input_signal[i] through a STAGES-deep flop chain; last stage is sync_out[i].
REQ-014 Each channel SHALL own a counter cnt[i] of width clog2(FILTER_LEN+1); threshold T = filter_en ? FILTER_LEN : 1.
REQ-015 If sync_out[i] == output_signal[i], cnt[i] SHALL clear to 0 on the next edge.
REQ-016 If sync_out[i] != output_signal[i] and cnt[i] >= T-1, output_signal[i] SHALL load sync_out[i] and cnt[i] SHALL clear, same edge.
REQ-017 If sync_out[i] != output_signal[i] and cnt[i] < T-1, cnt[i] SHALL increment; output_signal[i] holds.
REQ-018 Comparison SHALL be >= so filter_en falling mid-count updates output on the next differing edge; counter never wraps.
REQ-019 Latency: input stable from before edge 1 -> output_signal changes at edge STAGES+T (bypass, STAGES=2: edge 3).
REQ-020 Any sync_out level lasting fewer than T consecutive cycles SHALL be rejected with no output change and no pulse.
REQ-021 rise_pulse[i]/fall_pulse[i] SHALL assert on the same edge output_signal[i] changes and deassert on the next edge.
REQ-022 rise_pulse[i] and fall_pulse[i] SHALL never be high together; channels operate fully independently and simultaneously.
REQ-023 change_any SHALL be combinational OR of registered pulses, adding no latency.
REQ-024 filter_en changes SHALL NOT clear counters or alter output_signal directly.

Reset
REQ-025 While cdc_rstn==0 at a rising edge: sync chain and output_signal <= RESET_VAL; cnt, rise_pulse, fall_pulse <= 0.
REQ-026 Reset SHALL override any in-progress count; no pulse SHALL be generated by reset entry or exit.
REQ-027 After release, first edge SHALL resume normal sampling; an input differing from RESET_VAL produces a normal pulse after REQ-019 latency.

Verification (WIDTH=5, STAGES=2, FILTER_LEN=4)
REQ-028 Reset: input=5'h1F, cdc_rstn=0 for 3 edges -> output_signal=0, rise/fall=0, change_any=0 throughout.
REQ-029 Bypass: filter_en=0, input 0->5'h03 before edge 1 -> output_signal=5'h03 after edge 3, rise_pulse=5'h03 exactly one cycle, change_any=1 that cycle.
REQ-030 Filter: filter_en=1, input[0] 0->1 held -> output_signal[0]=1 after edge 6, rise_pulse[0] one cycle; later 1->0 -> fall_pulse[0] one cycle 6 edges after.
REQ-031 Glitch: filter_en=1, input[2] high 3 cycles then low -> output_signal[2] stays 0, no pulse; 4-cycle high -> accepted.
REQ-032 Mode switch: filter_en=1, input[4] rises, filter_en->0 when cnt[4]=2 -> output_signal[4]=1 on next edge, single rise_pulse.
REQ-033 Reset mid-count: output[1]=1, input[1] drops, cdc_rstn=0 two edges later -> output[1]=0 (RESET_VAL), fall_pulse[1] never asserts, cnt cleared.
